// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction memory. Takes a byte stream from a host or
// boot channel and packs every four bytes into one big-endian 32-bit SPARC
// instruction word, with the first byte in bits 31:24. Each word is written to
// the instruction memory at the next word-aligned byte address, starting at 0.
// The fetch pipeline is held frozen until the whole image has been written.
//
// Ports:
//   clk         in   1      clock, all logic on posedge
//   R           in   1      synchronous active-low reset
//   start       in   1      single-cycle request to begin a load
//   len_words   in   LEN_W  program length in words, sampled on accepted start
//   byte_in     in   8      stream data byte
//   byte_valid  in   1      byte_in valid
//   byte_ready  out  1      loader accepts a byte this cycle
//   mem_we      out  1      instruction memory write strobe (single cycle)
//   mem_addr    out  32     word-aligned byte address (word_idx << 2)
//   mem_wdata   out  32     assembled instruction word
//   busy        out  1      load in progress
//   done        out  1      image loaded; held until next accepted start
//   cpu_hold    out  1      1 = freeze PC/nPC and clear IF/ID
//   err         out  1      last start rejected because of a bad length
//
// All outputs are registers. Each is loaded from the next-state decode so that
// it lines up with the state it describes in the same cycle.
//------------------------------------------------------------------------------
module imem_loader #(
    parameter int NUM_WORDS = 128,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             R,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold,
    output logic             err
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [31:0] NUM_WORDS_U = 32'(NUM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Big-endian assembly: older bytes move toward the MSB.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                  input logic [7:0]  b);
        return {word[23:0], b};
    endfunction

    // Word index widened to a 32-bit byte address.
    function automatic logic [31:0] idx_to_addr(input logic [IDX_W-1:0] idx);
        return {{(30-IDX_W){1'b0}}, idx, 2'b00};
    endfunction

    // Control state
    state_t           state_q,    state_d;
    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [LEN_W-1:0] len_q,      len_d;
    logic [31:0]      asm_q,      asm_d;
    logic             err_q,      err_d;

    // Registered outputs
    logic             byte_ready_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic             busy_q;
    logic             done_q;
    logic             cpu_hold_q;

    // Decoded helpers
    logic             xfer_s;
    logic             len_zero_s;
    logic             len_big_s;
    logic             last_word_s;

    // byte_ready_q is only set while in LOAD, so this also gates on state.
    assign xfer_s      = byte_valid && byte_ready_q;
    assign len_zero_s  = (len_words == {LEN_W{1'b0}});
    assign len_big_s   = ({{(32-LEN_W){1'b0}}, len_words} > NUM_WORDS_U);
    // len_q is never zero in LOAD/WRITE, so len_q-1 cannot underflow there.
    assign last_word_s = ({{(32-IDX_W){1'b0}}, word_idx_q} ==
                          ({{(32-LEN_W){1'b0}}, len_q} - 32'd1));

    // Next-state and datapath update decode.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        asm_d      = asm_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (len_zero_s) begin
                        // Empty image: nothing to write, release the CPU.
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if (len_big_s) begin
                        // Image does not fit; flag it and stay put.
                        err_d   = 1'b1;
                        state_d = state_q;
                    end else begin
                        len_d      = len_words;
                        err_d      = 1'b0;
                        byte_cnt_d = 3'd0;
                        word_idx_d = {IDX_W{1'b0}};
                        asm_d      = 32'd0;
                        state_d    = ST_LOAD;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_LOAD: begin
                // start is ignored while a load is in progress.
                if (xfer_s) begin
                    asm_d      = shift_in_byte(asm_q, byte_in);
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd3) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    // Stream gap: hold the partial word and count.
                    state_d = ST_LOAD;
                end
            end

            ST_WRITE: begin
                if (last_word_s) begin
                    state_d = ST_DONE;
                end else begin
                    word_idx_d = word_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    byte_cnt_d = 3'd0;
                    state_d    = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!R) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 3'd0;
            word_idx_q <= {IDX_W{1'b0}};
            len_q      <= {LEN_W{1'b0}};
            asm_q      <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            asm_q      <= asm_d;
            err_q      <= err_d;
        end
    end

    // Output registers decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (!R) begin
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            byte_ready_q <= (state_d == ST_LOAD);
            // WRITE always exits after one cycle, so mem_we never repeats.
            mem_we_q     <= (state_d == ST_WRITE);
            busy_q       <= (state_d == ST_LOAD) || (state_d == ST_WRITE);
            done_q       <= (state_d == ST_DONE);
            cpu_hold_q   <= (state_d != ST_DONE);
            // Address/data only move when a write is issued and hold otherwise.
            if (state_d == ST_WRITE) begin
                mem_addr_q  <= idx_to_addr(word_idx_q);
                mem_wdata_q <= asm_d;
            end else begin
                mem_addr_q  <= mem_addr_q;
                mem_wdata_q <= mem_wdata_q;
            end
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cpu_hold   = cpu_hold_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Inputs change 1 time unit after the rising
// edge and outputs are sampled at that same point. A negedge monitor counts
// write strobes and back-to-back strobes. Status flags are compared packed as
// {byte_ready, mem_we, busy, done, err, cpu_hold}.
//------------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        R;
    logic        start;
    logic [7:0]  len_words;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        cpu_hold;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int dbl_cnt = 0;
    logic prev_we = 1'b0;

    imem_loader #(.NUM_WORDS(128), .LEN_W(8)) dut (
        .clk        (clk),
        .R          (R),
        .start      (start),
        .len_words  (len_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write strobe monitor
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            if (prev_we === 1'b1) dbl_cnt = dbl_cnt + 1;
        end
        prev_we = mem_we;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {26'd0, byte_ready, mem_we, busy, done, err, cpu_hold};
    endfunction

    task automatic do_reset();
        R = 1'b0;
        tick();
        R = 1'b1;
    endtask

    task automatic do_start(input logic [7:0] len);
        start = 1'b1;
        len_words = len;
        tick();
        start = 1'b0;
    endtask

    // Present a byte and hold it until the loader takes it (bounded).
    task automatic push_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (byte_ready !== 1'b1) check_eq("ready_timeout", 32'(byte_ready), 32'd1);
        else tick();
        byte_valid = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [31:0] addr,
                               input logic [31:0] data);
        check_eq({tag, "_we"},   32'(mem_we), 32'd1);
        check_eq({tag, "_addr"}, mem_addr,    addr);
        check_eq({tag, "_data"}, mem_wdata,   data);
    endtask

    logic [7:0]  img [8];
    logic [31:0] w_exp;
    int base_wr;
    int drops;

    initial begin
        img[0] = 8'h81; img[1] = 8'hC3; img[2] = 8'hE0; img[3] = 8'h08;
        img[4] = 8'h01; img[5] = 8'h00; img[6] = 8'h00; img[7] = 8'h00;

        R = 1'b0; start = 1'b0; len_words = 8'd0; byte_in = 8'd0; byte_valid = 1'b0;
        tick();
        tick();
        // Reset state
        check_eq("rst_flags", flags(), 32'b000001);
        check_eq("rst_addr",  mem_addr,  32'd0);
        check_eq("rst_data",  mem_wdata, 32'd0);
        R = 1'b1;
        tick();

        // Two-word image, byte_valid held high
        base_wr = wr_cnt;
        do_start(8'd2);
        check_eq("t1_load_flags", flags(), 32'b101001);
        for (int i = 0; i < 8; i++) begin
            push_byte(img[i]);
            if (i == 3) check_write("t1_w0", 32'h0, 32'h81C3E008);
            if (i == 7) check_write("t1_w1", 32'h4, 32'h01000000);
        end
        tick();
        check_eq("t1_done_flags", flags(), 32'b000100);
        check_eq("t1_wr_cnt", 32'(wr_cnt - base_wr), 32'd2);

        // Same image with 3-cycle gaps between bytes, restarted from DONE
        base_wr = wr_cnt;
        drops = 0;
        do_start(8'd2);
        check_eq("t2_restart_flags", flags(), 32'b101001);
        for (int i = 0; i < 8; i++) begin
            push_byte(img[i]);
            if (i == 3) check_write("t2_w0", 32'h0, 32'h81C3E008);
            if (i == 7) check_write("t2_w1", 32'h4, 32'h01000000);
            for (int g = 0; g < 3; g++) begin
                tick();
                if ((i % 4) != 3 && byte_ready !== 1'b1) drops++;
            end
        end
        check_eq("t2_gap_ready", 32'(drops), 32'd0);
        check_eq("t2_wr_cnt", 32'(wr_cnt - base_wr), 32'd2);
        check_eq("t2_done_flags", flags(), 32'b000100);

        // Zero-length image from IDLE; stray bytes are ignored
        do_reset();
        check_eq("t3_idle_flags", flags(), 32'b000001);
        base_wr = wr_cnt;
        do_start(8'd0);
        check_eq("t3_done_flags", flags(), 32'b000100);
        byte_in = 8'h55;
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        byte_valid = 1'b0;
        check_eq("t3_no_write", 32'(wr_cnt - base_wr), 32'd0);
        check_eq("t3_still_done", flags(), 32'b000100);

        // Oversize length rejected, then a good one-word load clears err
        do_reset();
        do_start(8'd129);
        check_eq("t4_err_flags", flags(), 32'b000011);
        do_start(8'd1);
        check_eq("t4_load_flags", flags(), 32'b101001);
        push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
        check_write("t4_w0", 32'h0, 32'hDEADBEEF);
        tick();
        check_eq("t4_done_flags", flags(), 32'b000100);

        // Reset in the middle of a word discards it
        base_wr = wr_cnt;
        do_start(8'd1);
        push_byte(8'hAA); push_byte(8'hBB);
        do_reset();
        check_eq("t5_rst_flags", flags(), 32'b000001);
        check_eq("t5_rst_addr",  mem_addr,  32'd0);
        check_eq("t5_rst_data",  mem_wdata, 32'd0);
        check_eq("t5_no_write",  32'(wr_cnt - base_wr), 32'd0);
        // New load; a start pulse during LOAD must not restart it
        do_start(8'd1);
        push_byte(8'h11); push_byte(8'h22);
        do_start(8'd2);
        check_eq("t5_busy_start", flags(), 32'b101001);
        push_byte(8'h33); push_byte(8'h44);
        check_write("t5_w0", 32'h0, 32'h11223344);
        tick();
        check_eq("t5_done_flags", flags(), 32'b000100);

        // start and reset together: reset wins
        start = 1'b1; len_words = 8'd1; R = 1'b0;
        tick();
        start = 1'b0; R = 1'b1;
        check_eq("t5_rst_wins", flags(), 32'b000001);

        // Finish a one-word load, then reload and rewrite address 0
        do_start(8'd1);
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
        check_write("t6_first", 32'h0, 32'h01020304);
        tick();
        check_eq("t6_done_flags", flags(), 32'b000100);
        do_start(8'd1);
        check_eq("t6_reload_flags", flags(), 32'b101001);
        push_byte(8'hA5); push_byte(8'h5A); push_byte(8'hC3); push_byte(8'h3C);
        check_write("t6_rewrite", 32'h0, 32'hA55AC33C);
        tick();

        // Full-depth image: last word lands at 0x1FC
        base_wr = wr_cnt;
        do_start(8'd128);
        check_eq("t7_load_flags", flags(), 32'b101001);
        for (int w = 0; w < 128; w++) begin
            logic [7:0] wb;
            wb = 8'(w);
            push_byte(wb); push_byte(8'hA5); push_byte(8'h5A); push_byte(~wb);
            if (w == 0)   check_write("t7_first", 32'h0,   32'h00A55AFF);
            if (w == 127) check_write("t7_last",  32'h1FC, 32'h7FA55A80);
        end
        tick();
        check_eq("t7_done_flags", flags(), 32'b000100);
        check_eq("t7_wr_cnt", 32'(wr_cnt - base_wr), 32'd128);
        check_eq("no_double_we", 32'(dbl_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
